// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, stage bundle layouts and bubble constants
// used by the pipeline-register bank.
package y86_pkg;

  localparam logic [3:0] AOK = 4'h1;
  localparam logic [3:0] HLT = 4'h2;
  localparam logic [3:0] ADR = 4'h3;
  localparam logic [3:0] INS = 4'h4;

  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } fd_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } de_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        Cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } em_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mw_t;

  localparam fd_t FD_BUBBLE = '{stat: AOK, icode: NOP, ifun: 4'h0, rA: RNONE, rB: RNONE,
                                valC: 64'h0, valP: 64'h0};
  localparam de_t DE_BUBBLE = '{stat: AOK, icode: NOP, ifun: 4'h0, valC: 64'h0, valA: 64'h0,
                                valB: 64'h0, dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};
  localparam em_t EM_BUBBLE = '{stat: AOK, icode: NOP, Cnd: 1'b0, valE: 64'h0, valA: 64'h0,
                                dstE: RNONE, dstM: RNONE};
  localparam mw_t MW_BUBBLE = '{stat: AOK, icode: NOP, valE: 64'h0, valM: 64'h0,
                                dstE: RNONE, dstM: RNONE};

  // True for the status codes that stop the machine once they reach writeback.
  function automatic logic isFault(input logic [3:0] stat);
    return (stat == HLT) || (stat == ADR) || (stat == INS);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: reset and bubble both load BUBBLE_VAL,
// stall holds, and stall outranks bubble when both are raised.
module pipe_stage_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             conflict
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = din;
    if (stall) begin
      data_d = data_q;
    end else if (bubble) begin
      data_d = BUBBLE_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= BUBBLE_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign dout     = data_q;
  assign conflict = stall & bubble;

endmodule

// File: rtl/y86_pipe_regs.sv
// Y86-64 pipeline-register bank: F/D/E/M/W registers under stall/bubble
// control, plus sticky halt/control-error flags and cycle/retire counters.
module y86_pipe_regs
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        W_stall,
  input  logic        D_bubble,
  input  logic        E_bubble,
  input  logic        M_bubble,
  input  logic [63:0] f_predPC,
  input  fd_t         f_out,
  input  de_t         d_out,
  input  em_t         e_out,
  input  mw_t         m_out,
  output logic [63:0] F_predPC,
  output fd_t         D_reg,
  output de_t         E_reg,
  output em_t         M_reg,
  output mw_t         W_reg,
  output logic        halted,
  output logic [63:0] cyc_count,
  output logic [63:0] ret_count,
  output logic        ctl_err
);

  logic [63:0] predPC_q, predPC_d;
  logic        halted_q, halted_d;
  logic [63:0] cycCount_q, cycCount_d;
  logic [63:0] retCount_q, retCount_d;
  logic        ctlErr_q, ctlErr_d;
  logic        dConflict, eConflict, mConflict, wConflict;

  pipe_stage_reg #(.WIDTH($bits(fd_t)), .BUBBLE_VAL(FD_BUBBLE)) uDReg (
    .clk(clk), .rst(rst), .stall(D_stall), .bubble(D_bubble),
    .din(f_out), .dout(D_reg), .conflict(dConflict)
  );

  pipe_stage_reg #(.WIDTH($bits(de_t)), .BUBBLE_VAL(DE_BUBBLE)) uEReg (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(E_bubble),
    .din(d_out), .dout(E_reg), .conflict(eConflict)
  );

  pipe_stage_reg #(.WIDTH($bits(em_t)), .BUBBLE_VAL(EM_BUBBLE)) uMReg (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(M_bubble),
    .din(e_out), .dout(M_reg), .conflict(mConflict)
  );

  pipe_stage_reg #(.WIDTH($bits(mw_t)), .BUBBLE_VAL(MW_BUBBLE)) uWReg (
    .clk(clk), .rst(rst), .stall(W_stall), .bubble(1'b0),
    .din(m_out), .dout(W_reg), .conflict(wConflict)
  );

  // Retirement is counted as W loads, so the faulting instruction itself is counted once.
  always_comb begin
    predPC_d   = F_stall ? predPC_q : f_predPC;
    halted_d   = halted_q | isFault(W_reg.stat);
    cycCount_d = halted_q ? cycCount_q : cycCount_q + 64'd1;
    retCount_d = retCount_q;
    if (!W_stall && !halted_q && (m_out.icode != NOP)) begin
      retCount_d = retCount_q + 64'd1;
    end
    ctlErr_d   = ctlErr_q | dConflict | eConflict | mConflict | wConflict;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      predPC_q   <= RESET_PC;
      halted_q   <= 1'b0;
      cycCount_q <= 64'd0;
      retCount_q <= 64'd0;
      ctlErr_q   <= 1'b0;
    end else begin
      predPC_q   <= predPC_d;
      halted_q   <= halted_d;
      cycCount_q <= cycCount_d;
      retCount_q <= retCount_d;
      ctlErr_q   <= ctlErr_d;
    end
  end

  assign F_predPC  = predPC_q;
  assign halted    = halted_q;
  assign cyc_count = cycCount_q;
  assign ret_count = retCount_q;
  assign ctl_err   = ctlErr_q;

endmodule

// File: tb/tb_y86_pipe_regs.sv
// Directed self-checking bench for y86_pipe_regs: reset, load-use, misprediction,
// return, control conflict, halt and reset recovery.
module tb_y86_pipe_regs;
  import y86_pkg::*;

  logic        clk;
  logic        rst;
  logic        F_stall, D_stall, W_stall;
  logic        D_bubble, E_bubble, M_bubble;
  logic [63:0] fPredPC;
  fd_t         fOut;
  de_t         dOut;
  em_t         eOut;
  mw_t         mOut;
  logic [63:0] F_predPC;
  fd_t         D_reg;
  de_t         E_reg;
  em_t         M_reg;
  mw_t         W_reg;
  logic        halted;
  logic [63:0] cycCount;
  logic [63:0] retCount;
  logic        ctlErr;

  int checks   = 0;
  int failures = 0;

  // Bubble images written out field by field, independent of the package constants.
  logic [147:0] fdBub = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
  logic [219:0] deBub = {4'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [144:0] emBub = {4'h1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};
  logic [143:0] mwBub = {4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF};

  y86_pipe_regs #(.RESET_PC(64'h100)) dut (
    .clk(clk), .rst(rst),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .f_predPC(fPredPC), .f_out(fOut), .d_out(dOut), .e_out(eOut), .m_out(mOut),
    .F_predPC(F_predPC), .D_reg(D_reg), .E_reg(E_reg), .M_reg(M_reg), .W_reg(W_reg),
    .halted(halted), .cyc_count(cycCount), .ret_count(retCount), .ctl_err(ctlErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fd_t mkF(input logic [63:0] k);
    return {4'h1, 4'h3, 4'h0, 4'hF, 4'h2, k, k + 64'd10};
  endfunction

  function automatic de_t mkD(input logic [63:0] k);
    return {4'h1, 4'h5, 4'h0, k, k + 64'd1, k + 64'd2, 4'h3, 4'h4, 4'h5, 4'h6};
  endfunction

  function automatic em_t mkE(input logic [63:0] k);
    return {4'h1, 4'h3, 1'b1, k, k + 64'd3, 4'h2, 4'hF};
  endfunction

  function automatic mw_t mkM(input logic [3:0] stat, input logic [3:0] icode, input logic [63:0] k);
    return {stat, icode, k, k + 64'd5, 4'h1, 4'hF};
  endfunction

  // Compares one observed value against its expected value and tallies the result.
  task automatic checkOutput(input string tag, input logic [223:0] got, input logic [223:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Sets every control input at once; inputs change 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic fs, input logic ds, input logic ws,
                               input logic db, input logic eb, input logic mb);
    rst = r; F_stall = fs; D_stall = ds; W_stall = ws;
    D_bubble = db; E_bubble = eb; M_bubble = mb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_F"}, F_predPC, 64'h100);
    checkOutput({tag, "_D"}, D_reg, fdBub);
    checkOutput({tag, "_E"}, E_reg, deBub);
    checkOutput({tag, "_M"}, M_reg, emBub);
    checkOutput({tag, "_W"}, W_reg, mwBub);
    checkOutput({tag, "_cyc"}, cycCount, 64'd0);
    checkOutput({tag, "_ret"}, retCount, 64'd0);
    checkOutput({tag, "_halted"}, halted, 1'b0);
    checkOutput({tag, "_ctlerr"}, ctlErr, 1'b0);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    fPredPC = 64'h0; fOut = mkF(64'h99); dOut = mkD(64'h99); eOut = mkE(64'h99);
    mOut = mkM(4'h1, 4'h3, 64'h99);
    tick(); tick();
    checkResetState("reset");

    // Plain load of every register.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    fPredPC = 64'h200; fOut = mkF(64'h1000); dOut = mkD(64'h2000); eOut = mkE(64'h3000);
    mOut = mkM(4'h1, 4'h3, 64'h4000);
    tick();
    checkOutput("load_F", F_predPC, 64'h200);
    checkOutput("load_D", D_reg, mkF(64'h1000));
    checkOutput("load_E", E_reg, mkD(64'h2000));
    checkOutput("load_M", M_reg, mkE(64'h3000));
    checkOutput("load_W", W_reg, mkM(4'h1, 4'h3, 64'h4000));
    checkOutput("load_cyc", cycCount, 64'd1);
    checkOutput("load_ret", retCount, 64'd1);

    // Load-use hazard; a genuine nop enters W and is not counted.
    applyStimulus(0, 1, 1, 0, 0, 1, 0);
    fPredPC = 64'h300; fOut = mkF(64'h1100); dOut = mkD(64'h2100); eOut = mkE(64'h3100);
    mOut = mkM(4'h1, 4'h1, 64'h4100);
    tick();
    checkOutput("lu_F", F_predPC, 64'h200);
    checkOutput("lu_D", D_reg, mkF(64'h1000));
    checkOutput("lu_E", E_reg, deBub);
    checkOutput("lu_M", M_reg, mkE(64'h3100));
    checkOutput("lu_W", W_reg, mkM(4'h1, 4'h1, 64'h4100));
    checkOutput("lu_ret", retCount, 64'd1);
    checkOutput("lu_ctlerr", ctlErr, 1'b0);

    // Misprediction squashes D and E.
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    fPredPC = 64'h400; fOut = mkF(64'h1200); dOut = mkD(64'h2200); eOut = mkE(64'h3200);
    mOut = mkM(4'h1, 4'h5, 64'h4200);
    tick();
    checkOutput("mp_F", F_predPC, 64'h400);
    checkOutput("mp_D", D_reg, fdBub);
    checkOutput("mp_E", E_reg, deBub);
    checkOutput("mp_M", M_reg, mkE(64'h3200));
    checkOutput("mp_ret", retCount, 64'd2);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    fOut = mkF(64'h1300); dOut = deBub; eOut = emBub; mOut = mwBub;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("mp_W_bubble", W_reg, mwBub);
    checkOutput("mp_ret_late", retCount, 64'd2);
    checkOutput("mp_cyc", cycCount, 64'd6);

    // Return handling: fetch frozen, D held as a bubble for three cycles.
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      fPredPC = 64'h500 + 64'(i);
      tick();
      checkOutput($sformatf("ret_F_%0d", i), F_predPC, 64'h400);
      checkOutput($sformatf("ret_D_%0d", i), D_reg, fdBub);
    end
    checkOutput("ret_cyc", cycCount, 64'd9);

    // Stall and bubble together on D: stall wins and the error flag sticks.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    fOut = mkF(64'h1600);
    tick();
    checkOutput("cf_pre_D", D_reg, mkF(64'h1600));
    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    fOut = mkF(64'h1700);
    tick();
    checkOutput("cf_D_hold", D_reg, mkF(64'h1600));
    checkOutput("cf_ctlerr", ctlErr, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("cf_D_after", D_reg, mkF(64'h1700));
    checkOutput("cf_ctlerr_sticky", ctlErr, 1'b1);
    checkOutput("cf_cyc", cycCount, 64'd12);

    // Halt reaches W, then W is stalled.
    mOut = mkM(4'h2, 4'h0, 64'h4800);
    tick();
    checkOutput("h_W_stat", W_reg.stat, 4'h2);
    checkOutput("h_halted_early", halted, 1'b0);
    checkOutput("h_ret", retCount, 64'd3);
    checkOutput("h_cyc", cycCount, 64'd13);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    mOut = mkM(4'h1, 4'h3, 64'h4900);
    tick();
    checkOutput("h_halted", halted, 1'b1);
    checkOutput("h_W_hold", W_reg, mkM(4'h2, 4'h0, 64'h4800));
    checkOutput("h_cyc_edge", cycCount, 64'd14);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("h_cyc_frozen", cycCount, 64'd14);
    checkOutput("h_ret_frozen", retCount, 64'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    fPredPC = 64'h700;
    tick();
    checkOutput("h_W_reload", W_reg, mkM(4'h1, 4'h3, 64'h4900));
    checkOutput("h_F_still_live", F_predPC, 64'h700);
    checkOutput("h_halted_sticky", halted, 1'b1);
    checkOutput("h_ret_no_count", retCount, 64'd3);
    checkOutput("h_cyc_still", cycCount, 64'd14);

    // Reset overrides stalls and clears all sticky state.
    applyStimulus(1, 1, 1, 1, 1, 1, 1);
    tick();
    checkResetState("rst2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y86_pipe_regs.md
# y86_pipe_regs

Pipeline-register bank for the Y86-64 pipelined processor. It holds the F, D, E, M and W stage registers and applies the stall and bubble commands from the pipeline control logic. It also maintains a sticky halt flag and two performance counters. It sits between the combinational stage logic (fetch, decode, execute, memory) and the control block, consuming that block's outputs every cycle.

## Interface
- `RESET_PC`, default 64'h0, value loaded into F_predPC on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `F_stall`, `D_stall`, `W_stall`  in  1 each  hold the named register.
- `D_bubble`, `E_bubble`, `M_bubble`  in  1 each  load the bubble value into the named register.
- `f_predPC`  in  64  next predicted PC from fetch.
- `f_out`  in  148  fetch bundle: stat, icode, ifun, rA, rB, valC, valP.
- `d_out`  in  220  decode bundle: stat, icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB.
- `e_out`  in  145  execute bundle: stat, icode, Cnd, valE, valA, dstE, dstM.
- `m_out`  in  144  memory bundle: stat, icode, valE, valM, dstE, dstM.
- `F_predPC`  out  64  F register.
- `D_reg`, `E_reg`, `M_reg`, `W_reg`  out  148/220/145/144  stage registers, same layouts as their inputs.
- `halted`  out  1  sticky: W_reg.stat ≠ AOK has been seen.
- `cyc_count`  out  64  cycles since reset, frozen while halted.
- `ret_count`  out  64  instructions retired.
- `ctl_err`  out  1  sticky: stall and bubble were both asserted for one register in the same cycle.

## Operation
- Per register, each cycle, in priority order:
  1. `rst`
  2. stall: hold
  3. bubble: load bubble value
  4. otherwise: load the input bundle
- Which command applies to each register:
  - F: stall only.
  - D: stall and bubble.
  - E: bubble only.
  - M: bubble only.
  - W: stall only.
- Bubble value:
  - stat = AOK (1), icode = NOP (1), ifun = 0.
  - All register-ID fields (rA, rB, srcA, srcB, dstE, dstM) = RNONE (4'hF).
  - All data fields and Cnd = 0.
- Reset value:
  - F_predPC = RESET_PC.
  - D_reg, E_reg, M_reg, W_reg = bubble value.
  - halted = 0, cyc_count = 0, ret_count = 0, ctl_err = 0.
- `ctl_err` is set when D_stall and D_bubble are both 1 in a cycle. The stall wins; D_reg holds. `ctl_err` clears only on `rst`.
- `halted` is set on the cycle after W_reg.stat becomes HLT (2), ADR (3) or INS (4). It clears only on `rst`.
- `cyc_count` increments every non-reset cycle while halted = 0. It wraps at 2^64.
- `ret_count` increments when W_reg loads from `m_out` (no `rst`, no W_stall), halted = 0, and m_out.icode ≠ NOP. Bubbles are never counted, and neither are genuine nops.
- After halted = 1, registers keep obeying their stall and bubble inputs. Control is responsible for freezing them.

## Timing
- Every output is registered. There is no combinational path from any input to any output.
- Latency through each register is 1 cycle. A command asserted in cycle n affects the register value visible in cycle n+1.
- A stalled register holds its value for exactly as many cycles as stall is asserted.
- Asserting `rst` mid-stall or mid-halt restores all reset values on the next edge, regardless of any other input.
- `halted` rises 1 cycle after the faulting W_reg value appears. `cyc_count` stops incrementing from that same cycle.

## Structure
- Package `y86_pkg` contains:
  - Status codes: AOK = 1, HLT = 2, ADR = 3, INS = 4.
  - Icodes: NOP = 1, IRMOVQ = 3, MRMOVQ = 5, JXX = 7, RET = 9, POPQ = 11.
  - RNONE = 4'hF.
  - Packed bundle structs for F→D, D→E, E→M and M→W.
  - Per-bundle bubble constants.
- Sub-module `pipe_stage_reg` has parameters WIDTH and BUBBLE_VAL, and inputs stall and bubble. It is instantiated four times, once per stage register, with unused commands tied to 0. It outputs a conflict pulse used to set `ctl_err`.
- The top level adds F_predPC, the halt flag and the two counters.

## Test plan
- Reset: hold `rst` for 2 cycles with RESET_PC = 64'h100 → F_predPC = 64'h100; every stage register has icode 1, stat 1, dst fields F; both counters are 0.
- Load-use: F_stall = D_stall = E_bubble = 1 for 1 cycle → F_predPC and D_reg unchanged; E_reg is a bubble; M_reg holds the previous E_reg value.
- Misprediction: D_bubble = E_bubble = 1 for 1 cycle → D_reg and E_reg are bubbles; ret_count does not count them 3 cycles later.
- Return handling: F_stall = D_bubble = 1 for 3 cycles → F_predPC constant; D_reg remains a bubble for all 3 cycles.
- Halt: feed m_out.stat = HLT and hold W_stall = 1 from the next cycle → W_reg.stat = 2; halted = 1 one cycle later; cyc_count frozen; ret_count includes the halt instruction exactly once.
- Conflict and reset: D_stall = D_bubble = 1 → D_reg holds and ctl_err = 1 persists; then assert `rst` 1 cycle → ctl_err = 0 and all reset values restored.
